uart_wb_bridge: RTL and testbench

//   Parametrised Wishbone slave front-end for the UART register bank; successor to the fixed 8/32-bit wb interface.

---
 rtl/uart_wb_pkg.sv | 35 +++
 rtl/uart_wb_if.sv | 26 ++
 rtl/uart_wb_lane_dec.sv | 44 ++++
 rtl/uart_wb_bridge.sv | 163 ++++++++++++++++
 tb/tb_uart_wb_bridge.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_wb_pkg.sv
// Shared types for the UART Wishbone bridge: FSM encoding, debug window words, byte-select decode.
// Pure declarations; no latency or backpressure of its own.
package uart_wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ACK    = 3'd3,
        ST_ERR    = 3'd4
    } state_e;

    localparam int DBG_WORD_A = 2;
    localparam int DBG_WORD_B = 3;

    typedef struct packed {
        logic       ok;
        logic [1:0] idx;
    } lane_t;

    // One-hot check of a 4-bit byte select plus the index of the set bit.
    function automatic lane_t lane_valid(input logic [3:0] sel);
        lane_t r;
        r = '{ok: 1'b0, idx: 2'd0};
        case (sel)
            4'b0001: r = '{ok: 1'b1, idx: 2'd0};
            4'b0010: r = '{ok: 1'b1, idx: 2'd1};
            4'b0100: r = '{ok: 1'b1, idx: 2'd2};
            4'b1000: r = '{ok: 1'b1, idx: 2'd3};
            default: r = '{ok: 1'b0, idx: 2'd0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_wb_if.sv
// Wishbone slave-side signal bundle for the UART bridge.
// No latency; handshake is WB cyc/stb terminated by ack or err.
interface uart_wb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] wb_adr_i;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic [DATA_WIDTH-1:0] wb_dat_o;
    logic [3:0]            wb_sel_i;
    logic                  wb_we_i;
    logic                  wb_stb_i;
    logic                  wb_cyc_i;
    logic                  wb_ack_o;
    logic                  wb_err_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/uart_wb_lane_dec.sv
// Byte-lane / debug-window decode of a WB request into {valid, lane, dbg_hit}.
// Combinational, zero latency; no backpressure.
module uart_wb_lane_dec
    import uart_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEBUG_EN   = 1
) (
    input  logic [3:0]            sel_i,
    input  logic [ADDR_WIDTH-3:0] word_i,
    input  logic                  we_i,
    input  logic                  dbg_en_i,
    output logic                  valid_o,
    output logic [1:0]            lane_o,
    output logic                  dbg_hit_o
);

    localparam logic [ADDR_WIDTH-3:0] WORD_A = (ADDR_WIDTH-2)'(DBG_WORD_A);
    localparam logic [ADDR_WIDTH-3:0] WORD_B = (ADDR_WIDTH-2)'(DBG_WORD_B);

    lane_t oh;
    logic  in_window;

    always_comb begin
        oh        = lane_valid(sel_i);
        in_window = (DEBUG_EN != 0) && (DATA_WIDTH == 32) && !we_i && dbg_en_i &&
                    ((word_i == WORD_A) || (word_i == WORD_B));
        valid_o   = 1'b0;
        lane_o    = 2'd0;
        dbg_hit_o = 1'b0;
        if (DATA_WIDTH != 32) begin
            valid_o = 1'b1;
        end else if (in_window) begin
            // Inside the window only a full-word read is meaningful.
            valid_o   = (sel_i == 4'hF);
            dbg_hit_o = (sel_i == 4'hF);
        end else begin
            valid_o = oh.ok;
            lane_o  = oh.idx;
        end
    end

endmodule

// File: rtl/uart_wb_bridge.sv
// Wishbone slave front-end turning 8/32-bit WB cycles into single-byte UART register accesses.
// Latency 2+WAIT_STATES cycles stb->ack (1 for err); master is stalled by withholding ack.
module uart_wb_bridge
    import uart_wb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int WAIT_STATES = 0,
    parameter int DEBUG_EN    = 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    uart_wb_if.slave              wb,
    output logic [ADDR_WIDTH-1:0] reg_adr_o,
    output logic [7:0]            reg_dat_o,
    input  logic [7:0]            reg_dat_i,
    output logic                  reg_we_o,
    output logic                  reg_re_o,
    input  logic                  dbg_en_i,
    input  logic [31:0]           dbg_dat_i,
    output logic                  busy_o
);

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES - 1);

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [7:0]              wbyte_q, wbyte_d;
    logic                    we_q, we_d;
    logic [1:0]              lane_q, lane_d;
    logic                    dbg_q, dbg_d;
    logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;

    logic                    dec_valid;
    logic [1:0]              dec_lane;
    logic                    dec_dbg;
    logic [ADDR_WIDTH-1:0]   req_adr;
    logic [7:0]              req_byte;
    logic [DATA_WIDTH-1:0]   rd_word;

    uart_wb_lane_dec #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEBUG_EN   (DEBUG_EN)
    ) u_lane_dec (
        .sel_i     (wb.wb_sel_i),
        .word_i    (wb.wb_adr_i[ADDR_WIDTH-1:2]),
        .we_i      (wb.wb_we_i),
        .dbg_en_i  (dbg_en_i),
        .valid_o   (dec_valid),
        .lane_o    (dec_lane),
        .dbg_hit_o (dec_dbg)
    );

    assign req_adr = (DATA_WIDTH == 32) ? {wb.wb_adr_i[ADDR_WIDTH-1:2], dec_lane} : wb.wb_adr_i;

    generate
        if (DATA_WIDTH == 32) begin : g_w32
            assign req_byte = wb.wb_dat_i[{dec_lane, 3'b000} +: 8];
            // Read byte returns in its own lane; debug hits bypass the register bank entirely.
            assign rd_word  = dbg_q ? dbg_dat_i : (DATA_WIDTH'(reg_dat_i) << {lane_q, 3'b000});
        end else begin : g_w8
            logic unused_w8;
            assign req_byte  = wb.wb_dat_i[7:0];
            assign rd_word   = DATA_WIDTH'(reg_dat_i);
            assign unused_w8 = ^{dbg_dat_i, lane_q, dbg_q};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        wbyte_d = wbyte_q;
        we_d    = we_q;
        lane_d  = lane_q;
        dbg_d   = dbg_q;
        rdat_d  = rdat_q;
        case (state_q)
            ST_IDLE: begin
                if (wb.wb_cyc_i && wb.wb_stb_i) begin
                    if (!dec_valid) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_ACCESS;
                        adr_d   = req_adr;
                        wbyte_d = req_byte;
                        we_d    = wb.wb_we_i;
                        lane_d  = dec_lane;
                        dbg_d   = dec_dbg;
                    end
                end
            end
            ST_ACCESS: begin
                rdat_d = we_q ? '0 : rd_word;
                if (WAIT_STATES > 0) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_WAIT: begin
                // A dropped cycle abandons the access; any write already strobed stands.
                if (!wb.wb_cyc_i) begin
                    state_d = ST_IDLE;
                    adr_d   = '0;
                    wbyte_d = '0;
                    rdat_d  = '0;
                end else if (cnt_q == 3'd0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                adr_d   = '0;
                wbyte_d = '0;
                rdat_d  = '0;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            wbyte_q <= '0;
            we_q    <= 1'b0;
            lane_q  <= '0;
            dbg_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wbyte_q <= wbyte_d;
            we_q    <= we_d;
            lane_q  <= lane_d;
            dbg_q   <= dbg_d;
            rdat_q  <= rdat_d;
        end
    end

    assign wb.wb_dat_o = rdat_q;
    assign wb.wb_ack_o = (state_q == ST_ACK);
    assign wb.wb_err_o = (state_q == ST_ERR);
    assign reg_adr_o   = adr_q;
    assign reg_dat_o   = wbyte_q;
    assign reg_we_o    = (state_q == ST_ACCESS) && we_q;
    assign reg_re_o    = (state_q == ST_ACCESS) && !we_q && !dbg_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed bench for uart_wb_bridge: three instances (32b/0ws, 32b/3ws, 8b/2ws) driven from a vector table.
module tb_uart_wb_bridge;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0]  t_adr  [3];
    logic [31:0] t_wdat [3];
    logic [3:0]  t_sel  [3];
    logic        t_we   [3];
    logic        t_cyc  [3];
    logic        t_stb  [3];
    logic [7:0]  t_rd   [3];
    logic        t_den  [3];
    logic [31:0] t_dbg  [3];

    logic [31:0] o_dat   [3];
    logic        o_ack   [3];
    logic        o_err   [3];
    logic [4:0]  o_radr  [3];
    logic [7:0]  o_wbyte [3];
    logic        o_we    [3];
    logic        o_re    [3];
    logic        o_busy  [3];

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int DW = (g == 2) ? 8 : 32;
        uart_wb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(5)) wbi ();

        assign wbi.wb_adr_i = t_adr[g];
        assign wbi.wb_dat_i = t_wdat[g][DW-1:0];
        assign wbi.wb_sel_i = t_sel[g];
        assign wbi.wb_we_i  = t_we[g];
        assign wbi.wb_cyc_i = t_cyc[g];
        assign wbi.wb_stb_i = t_stb[g];
        assign o_dat[g]     = 32'(wbi.wb_dat_o);
        assign o_ack[g]     = wbi.wb_ack_o;
        assign o_err[g]     = wbi.wb_err_o;

        uart_wb_bridge #(
            .DATA_WIDTH  (DW),
            .ADDR_WIDTH  (5),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
            .DEBUG_EN    ((g == 2) ? 0 : 1)
        ) u_dut (
            .wb_clk_i  (clk),
            .wb_rst_i  (rst_n),
            .wb        (wbi),
            .reg_adr_o (o_radr[g]),
            .reg_dat_o (o_wbyte[g]),
            .reg_dat_i (t_rd[g]),
            .reg_we_o  (o_we[g]),
            .reg_re_o  (o_re[g]),
            .dbg_en_i  (t_den[g]),
            .dbg_dat_i (t_dbg[g]),
            .busy_o    (o_busy[g])
        );
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int d);
        return 64'({o_dat[d], o_radr[d], o_wbyte[d], o_ack[d], o_err[d], o_we[d], o_re[d], o_busy[d]});
    endfunction

    typedef struct {
        logic        acked;
        logic        erred;
        logic        pre_idle;
        logic        busy_ok;
        int          lat;
        int          nwe;
        int          nre;
        logic [4:0]  sadr;
        logic [7:0]  sbyte;
        logic [31:0] rdat;
    } res_t;

    typedef struct {
        int          d;
        logic [4:0]  adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic        we;
        logic [7:0]  rd;
        logic        den;
        logic [31:0] dbg;
        logic        e_ack;
        int          e_lat;
        int          e_nwe;
        int          e_nre;
        logic [4:0]  e_sadr;
        logic [7:0]  e_sbyte;
        logic [31:0] e_rdat;
    } vec_t;

    task automatic drive(input int d, input logic [4:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, input logic we, input logic [7:0] rd,
                         input logic den, input logic [31:0] dbg, input logic req);
        t_adr[d]  = adr;
        t_wdat[d] = wdat;
        t_sel[d]  = sel;
        t_we[d]   = we;
        t_rd[d]   = rd;
        t_den[d]  = den;
        t_dbg[d]  = dbg;
        t_cyc[d]  = req;
        t_stb[d]  = req;
    endtask

    // Issues one request and records strobes and termination; ends with the request withdrawn.
    task automatic run_txn(input vec_t v, output res_t r);
        r.acked = 0; r.erred = 0; r.lat = 0; r.nwe = 0; r.nre = 0;
        r.sadr = '0; r.sbyte = '0; r.rdat = '0; r.busy_ok = 1'b1;
        @(posedge clk); #1;
        r.pre_idle = !o_busy[v.d] && !o_ack[v.d] && !o_err[v.d] && (o_dat[v.d] == 32'h0);
        drive(v.d, v.adr, v.wdat, v.sel, v.we, v.rd, v.den, v.dbg, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (o_we[v.d]) begin r.nwe++; r.sadr = o_radr[v.d]; r.sbyte = o_wbyte[v.d]; end
            if (o_re[v.d]) begin r.nre++; r.sadr = o_radr[v.d]; end
            if (!o_busy[v.d]) r.busy_ok = 1'b0;
            if (o_ack[v.d] || o_err[v.d]) begin
                r.acked = o_ack[v.d];
                r.erred = o_err[v.d];
                r.lat   = c;
                r.rdat  = o_dat[v.d];
                break;
            end
        end
        t_cyc[v.d] = 1'b0;
        t_stb[v.d] = 1'b0;
    endtask

    task automatic check_res(input string tag, input vec_t v, input res_t r);
        chk({tag, "_term"},    {62'd0, r.acked, r.erred}, {62'd0, v.e_ack, !v.e_ack});
        chk({tag, "_lat"},     64'(r.lat), 64'(v.e_lat));
        chk({tag, "_nwe"},     64'(r.nwe), 64'(v.e_nwe));
        chk({tag, "_nre"},     64'(r.nre), 64'(v.e_nre));
        chk({tag, "_regadr"},  64'(r.sadr), 64'(v.e_sadr));
        chk({tag, "_regdat"},  64'(r.sbyte), 64'(v.e_sbyte));
        chk({tag, "_rdat"},    64'(r.rdat), 64'(v.e_rdat));
        chk({tag, "_preidle"}, 64'(r.pre_idle), 64'd1);
        chk({tag, "_busy"},    64'(r.busy_ok), 64'd1);
    endtask

    task automatic no_term(input string tag, input int d);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (o_ack[d] || o_err[d] || o_we[d] || o_re[d]) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    vec_t vecs[18];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        vec_t v;
        res_t r;
        int   nwe;

        // d, adr, wdat, sel, we, rd, den, dbg, e_ack, e_lat, e_nwe, e_nre, e_sadr, e_sbyte, e_rdat
        vecs[0]  = '{0, 5'h04, 32'h00AB0000, 4'b0100, 1'b1, 8'h00, 1'b0, 32'h0,        1'b1, 2, 1, 0, 5'h06, 8'hAB, 32'h0};
        vecs[1]  = '{0, 5'h10, 32'h0,        4'b1000, 1'b0, 8'h3C, 1'b0, 32'h0,        1'b1, 2, 0, 1, 5'h13, 8'h00, 32'h3C000000};
        vecs[2]  = '{0, 5'h1C, 32'h12345678, 4'b0001, 1'b1, 8'h00, 1'b0, 32'h0,        1'b1, 2, 1, 0, 5'h1C, 8'h78, 32'h0};
        vecs[3]  = '{0, 5'h04, 32'hFFFFFFFF, 4'b0110, 1'b1, 8'h00, 1'b0, 32'h0,        1'b0, 1, 0, 0, 5'h00, 8'h00, 32'h0};
        vecs[4]  = '{0, 5'h04, 32'h0,        4'b0000, 1'b0, 8'h55, 1'b0, 32'h0,        1'b0, 1, 0, 0, 5'h00, 8'h00, 32'h0};
        vecs[5]  = '{0, 5'h0C, 32'h0,        4'hF,    1'b0, 8'h11, 1'b1, 32'hDEADBEEF, 1'b1, 2, 0, 0, 5'h00, 8'h00, 32'hDEADBEEF};
        vecs[6]  = '{0, 5'h08, 32'h0,        4'b0010, 1'b0, 8'h11, 1'b1, 32'hDEADBEEF, 1'b0, 1, 0, 0, 5'h00, 8'h00, 32'h0};
        vecs[7]  = '{0, 5'h0C, 32'h0,        4'hF,    1'b0, 8'h11, 1'b0, 32'hDEADBEEF, 1'b0, 1, 0, 0, 5'h00, 8'h00, 32'h0};
        vecs[8]  = '{0, 5'h0C, 32'h01020304, 4'hF,    1'b1, 8'h00, 1'b1, 32'hDEADBEEF, 1'b0, 1, 0, 0, 5'h00, 8'h00, 32'h0};
        vecs[9]  = '{0, 5'h04, 32'h0,        4'b0010, 1'b0, 8'h77, 1'b1, 32'hDEADBEEF, 1'b1, 2, 0, 1, 5'h05, 8'h00, 32'h00007700};
        vecs[10] = '{1, 5'h08, 32'h0,        4'b0001, 1'b0, 8'h5A, 1'b0, 32'h0,        1'b1, 5, 0, 1, 5'h08, 8'h00, 32'h0000005A};
        vecs[11] = '{1, 5'h14, 32'hC3000000, 4'b1000, 1'b1, 8'h00, 1'b0, 32'h0,        1'b1, 5, 1, 0, 5'h17, 8'hC3, 32'h0};
        vecs[12] = '{1, 5'h08, 32'h0,        4'hF,    1'b0, 8'h44, 1'b1, 32'hCAFEF00D, 1'b1, 5, 0, 0, 5'h00, 8'h00, 32'hCAFEF00D};
        for (int i = 0; i < 4; i++)
            vecs[13+i] = '{2, 5'(i), 32'(8'h10 + i), 4'b0000, 1'b1, 8'h00, 1'b0, 32'h0,
                           1'b1, 4, 1, 0, 5'(i), 8'(8'h10 + i), 32'h0};
        vecs[17] = '{2, 5'h1F, 32'h0,        4'b0110, 1'b0, 8'h99, 1'b0, 32'h0,        1'b1, 4, 0, 1, 5'h1F, 8'h00, 32'h00000099};

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) drive(d, 5'h0, 32'h0, 4'h0, 1'b0, 8'h0, 1'b0, 32'h0, 1'b0);
        #3;
        for (int d = 0; d < 3; d++) chk($sformatf("reset_outs_d%0d", d), outs(d), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run_txn(vecs[i], r);
            check_res($sformatf("v%0d", i), vecs[i], r);
        end

        // Reset lands in the middle of a 3-wait-state read.
        @(posedge clk); #1;
        drive(1, 5'h08, 32'h0, 4'b0001, 1'b0, 8'h5A, 1'b0, 32'h0, 1'b1);
        repeat (2) @(posedge clk);
        #1 chk("rst_mid_busy", 64'(o_busy[1]), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_outs", outs(1), 64'h0);
        drive(1, 5'h08, 32'h0, 4'b0001, 1'b0, 8'h5A, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        no_term("rst_mid_noterm", 1);
        v = '{1, 5'h18, 32'h0, 4'b0100, 1'b0, 8'h6E, 1'b0, 32'h0, 1'b1, 5, 0, 1, 5'h1A, 8'h00, 32'h006E0000};
        run_txn(v, r);
        check_res("after_rst", v, r);

        // Master drops cyc during the wait phase of a write.
        @(posedge clk); #1;
        nwe = 0;
        drive(1, 5'h04, 32'h0000EE00, 4'b0010, 1'b1, 8'h00, 1'b0, 32'h0, 1'b1);
        @(posedge clk); #1;
        if (o_we[1]) nwe++;
        chk("abort_regadr", 64'(o_radr[1]), 64'h05);
        chk("abort_regdat", 64'(o_wbyte[1]), 64'hEE);
        @(posedge clk); #1;
        if (o_we[1]) nwe++;
        t_cyc[1] = 1'b0;
        t_stb[1] = 1'b0;
        @(posedge clk); #1;
        chk("abort_outs", outs(1), 64'h0);
        chk("abort_nwe", 64'(nwe), 64'd1);
        no_term("abort_noterm", 1);
        v = '{1, 5'h00, 32'h000000A5, 4'b0001, 1'b1, 8'h00, 1'b0, 32'h0, 1'b1, 5, 1, 0, 5'h00, 8'hA5, 32'h0};
        run_txn(v, r);
        check_res("after_abort", v, r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
